// File: rtl/i2c_axil_pkg.sv
// Shared AXI4-Lite definitions for the I2C register masters and slaves.
// Holds response codes, the command-master state encoding and per-port address widths.
package i2c_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    // M0 drives i2c_master_axil, M1 drives i2c_slave_axil
    localparam int M0_ADDR_WIDTH = 5;
    localparam int M1_ADDR_WIDTH = 4;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one response out.
// Every output is a register, so nothing here is combinational from the bus or command inputs.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready high, waiting for a command
// WR_REQ     | AWVALID/WVALID outstanding, each drops after its own handshake
// WR_RESP    | BREADY high, waiting for BVALID
// RD_REQ     | ARVALID outstanding
// RD_DATA    | RREADY high, waiting for RVALID
// RSP        | rsp_valid high with stable payload until rsp_ready
module axil_cmd_master
    import i2c_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = M0_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_write,

    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [2:0]             r_state;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic                   r_write;
    logic                   r_cmd_ready;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic [1:0]             r_rsp_resp;
    logic                   r_rsp_write;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;

    assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs   = r_wvalid  & M_AXI_WREADY;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_write     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cmd_ready comes up one cycle after reset release
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_write     <= cmd_write;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        if (cmd_write) begin
                            r_state   <= ST_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_REQ;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= ST_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_write <= r_write;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_write <= r_write;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_write     = r_rsp_write;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-programmable AXI-Lite slave, a transaction-level
// expectation queue with its own register image, and directed latency/corner cases.
module tb_axil_cmd_master;
    import i2c_axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;

    axil_cmd_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        write;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[32];
    logic [31:0] slv_mem[32];
    logic [4:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;

    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [4:0]  s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;

    int cyc = 0;
    int cmd_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, rsp_rise_cyc, rdy_rise_cyc, rsp_hs_cyc, bready_rise_cyc;
    int aw_vcycles, w_vcycles, ar_hs_n;
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;
    logic        last_write;

    bit          pv_aw, pv_aw_hs, pv_w, pv_w_hs, pv_ar, pv_ar_hs, pv_rsp, pv_rsp_hs, pv_bready, pv_cmd_ready;
    logic [4:0]  pv_awaddr, pv_araddr;
    logic [31:0] pv_wdata, pv_rdata;
    logic [3:0]  pv_wstrb;
    logic [1:0]  pv_resp;
    logic        pv_write;

    // The bench slave's error map: 0x1C answers SLVERR, 0x1D answers DECERR
    function automatic logic [1:0] resp_for(input logic [4:0] a);
        if (a == 5'h1C) return RESP_SLVERR;
        if (a == 5'h1D) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin : mon
        bit   h_cmd, h_aw, h_w, h_b, h_ar, h_r, h_rsp;
        exp_t e;
        h_cmd = 0; h_aw = 0; h_w = 0; h_b = 0; h_ar = 0; h_r = 0; h_rsp = 0;
        if (rst) begin
            exp_q.delete();
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            pv_aw = 0; pv_aw_hs = 0; pv_w = 0; pv_w_hs = 0; pv_ar = 0; pv_ar_hs = 0;
            pv_rsp = 0; pv_rsp_hs = 0; pv_bready = 0; pv_cmd_ready = 0;
        end else begin
            h_cmd = cmd_valid && cmd_ready;
            h_aw  = awvalid && awready;
            h_w   = wvalid && wready;
            h_b   = bvalid && bready;
            h_ar  = arvalid && arready;
            h_r   = rvalid && rready;
            h_rsp = rsp_valid && rsp_ready;

            if (cmd_ready)
                chk("idle_outputs_low", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
            if (bready) chk("bready_only_after_aw_and_w", 32'(b_pend), 32'h1);
            if (rready) chk("rready_only_after_ar", 32'(r_pend), 32'h1);
            if (pv_aw && !pv_aw_hs) chk("aw_held_stable", 32'({awvalid, awaddr}), 32'({1'b1, pv_awaddr}));
            if (pv_w && !pv_w_hs) begin
                chk("w_held_stable", 32'({wvalid, wstrb}), 32'({1'b1, pv_wstrb}));
                chk("wdata_stable", wdata, pv_wdata);
            end
            if (pv_ar && !pv_ar_hs) chk("ar_held_stable", 32'({arvalid, araddr}), 32'({1'b1, pv_araddr}));
            if (pv_rsp && !pv_rsp_hs) begin
                chk("rsp_held_stable", 32'({rsp_valid, rsp_resp, rsp_write}), 32'({1'b1, pv_resp, pv_write}));
                chk("rsp_rdata_stable", rsp_rdata, pv_rdata);
            end

            if (h_cmd) begin
                cmd_cyc   = cyc;
                cur_addr  = cmd_addr;
                cur_wdata = cmd_wdata;
                cur_wstrb = cmd_wstrb;
                e.write   = cmd_write;
                e.resp    = resp_for(cmd_addr);
                if (cmd_write) begin
                    e.rdata = 32'h0;
                    if (e.resp == RESP_OKAY)
                        for (int b = 0; b < 4; b++)
                            if (cmd_wstrb[b]) ref_mem[cmd_addr][8*b +: 8] = cmd_wdata[8*b +: 8];
                end else begin
                    e.rdata = ref_mem[cmd_addr];
                end
                exp_q.push_back(e);
            end

            if (awvalid) aw_vcycles++;
            if (wvalid) w_vcycles++;
            if (h_aw) begin
                aw_cyc = cyc; chk("awaddr", 32'(awaddr), 32'(cur_addr));
                s_awaddr = awaddr; aw_got = 1; aw_cnt = 0;
            end
            if (h_w) begin
                w_cyc = cyc; chk("wdata", wdata, cur_wdata); chk("wstrb", 32'(wstrb), 32'(cur_wstrb));
                s_wdata = wdata; s_wstrb = wstrb; w_got = 1; w_cnt = 0;
            end
            if (h_b) begin b_cyc = cyc; b_pend = 0; end
            if (aw_got && w_got) begin
                if (resp_for(s_awaddr) == RESP_OKAY)
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) slv_mem[s_awaddr][8*b +: 8] = s_wdata[8*b +: 8];
                b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
            end
            if (h_ar) begin
                ar_cyc = cyc; ar_hs_n++; chk("araddr", 32'(araddr), 32'(cur_addr));
                s_araddr = araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0;
            end
            if (h_r) r_pend = 0;

            if (bready && !pv_bready) bready_rise_cyc = cyc;
            if (rsp_valid && !pv_rsp) rsp_rise_cyc = cyc;
            if (cmd_ready && !pv_cmd_ready) rdy_rise_cyc = cyc;

            if (h_rsp) begin
                rsp_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: response seen with no command outstanding");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    chk("rsp_write", 32'(rsp_write), 32'(e.write));
                end
                last_rdata = rsp_rdata; last_resp = rsp_resp; last_write = rsp_write;
            end

            pv_aw = awvalid; pv_aw_hs = h_aw; pv_awaddr = awaddr;
            pv_w = wvalid; pv_w_hs = h_w; pv_wdata = wdata; pv_wstrb = wstrb;
            pv_ar = arvalid; pv_ar_hs = h_ar; pv_araddr = araddr;
            pv_rsp = rsp_valid; pv_rsp_hs = h_rsp; pv_rdata = rsp_rdata;
            pv_resp = rsp_resp; pv_write = rsp_write;
            pv_bready = bready; pv_cmd_ready = cmd_ready;
        end
        cyc++;
        #1;
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        end else begin
            if (h_b) bvalid = 0;
            if (h_r) rvalid = 0;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end else awready = 0;
            if (wvalid)  begin wready  = (w_cnt >= w_delay);   w_cnt++;  end else wready  = 0;
            if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end else arready = 0;
            if (b_pend && !bvalid) begin
                if (b_cnt >= b_delay) begin bvalid = 1; bresp = resp_for(s_awaddr); end
                else b_cnt++;
            end
            if (r_pend && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1; rdata = slv_mem[s_araddr]; rresp = resp_for(s_araddr);
                end else r_cnt++;
            end
        end
    end

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        aw_delay = a; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bit acc;
        cmd_cyc = -1; aw_cyc = -1; w_cyc = -1; b_cyc = -1; ar_cyc = -1;
        rsp_rise_cyc = -1; rdy_rise_cyc = -1; rsp_hs_cyc = -1; bready_rise_cyc = -1;
        aw_vcycles = 0; w_vcycles = 0; ar_hs_n = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0; acc = 0;
        while (!acc && n < 100) begin
            @(posedge clk); acc = cmd_ready; n++; #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready low for %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_rsp(input bit rnd);
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < 300) begin
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); done = rsp_valid && rsp_ready; n++; #1;
        end
        rsp_ready = 1'b1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no response after %0d cycles, required one", n);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input bit rnd);
        send_cmd(wr, a, d, s);
        wait_rsp(rnd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  acc;
        logic wr;
        for (int i = 0; i < 32; i++) begin
            slv_mem[i] = 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'(i) * 32'h0101_0101;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_meta", 32'({rsp_resp, rsp_write}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'h1);

        // zero-wait write: AW/W at N+1, B at N+2, rsp at N+3, cmd_ready at N+4
        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b1, 5'h04, 32'hA5A5_0001, 4'hF, 1'b0);
        @(posedge clk); #1;
        chk("wr_aw_latency", 32'(aw_cyc - cmd_cyc), 32'd1);
        chk("wr_w_latency", 32'(w_cyc - cmd_cyc), 32'd1);
        chk("wr_b_latency", 32'(b_cyc - cmd_cyc), 32'd2);
        chk("wr_rsp_latency", 32'(rsp_rise_cyc - cmd_cyc), 32'd3);
        chk("wr_next_ready", 32'(rdy_rise_cyc - cmd_cyc), 32'd4);
        chk("wr_resp", 32'({last_resp, last_write}), 32'({2'b00, 1'b1}));
        chk("wr_rdata_zero", last_rdata, 32'h0);
        do_txn(1'b0, 5'h04, 32'h0, 4'h0, 1'b0);
        chk("readback_04", last_rdata, 32'hA5A5_0001);

        set_delays(3, 0, 0, 0, 0);
        do_txn(1'b1, 5'h0C, 32'h0BAD_F00D, 4'hF, 1'b0);
        chk("awdly_aw_cycles", 32'(aw_vcycles), 32'd4);
        chk("awdly_w_cycles", 32'(w_vcycles), 32'd1);
        chk("awdly_bready_rise", 32'(bready_rise_cyc - aw_cyc), 32'd1);
        set_delays(0, 3, 0, 0, 0);
        do_txn(1'b1, 5'h0C, 32'h1357_9BDF, 4'h5, 1'b0);
        chk("wdly_w_cycles", 32'(w_vcycles), 32'd4);
        chk("wdly_aw_cycles", 32'(aw_vcycles), 32'd1);
        chk("wdly_bready_rise", 32'(bready_rise_cyc - w_cyc), 32'd1);

        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b1, 5'h08, 32'h0000_00C3, 4'hF, 1'b0);
        set_delays(0, 0, 0, 0, 2);
        do_txn(1'b0, 5'h08, 32'h0, 4'h0, 1'b0);
        chk("rd_c3_data", last_rdata, 32'h0000_00C3);
        chk("rd_c3_write", 32'(last_write), 32'h0);
        chk("rd_c3_one_ar", 32'(ar_hs_n), 32'd1);
        chk("rd_c3_latency", 32'(rsp_rise_cyc - cmd_cyc), 32'd5);

        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b1, 5'h1C, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("slverr_passthru", 32'(last_resp), 32'h2);
        do_txn(1'b0, 5'h1D, 32'h0, 4'h0, 1'b0);
        chk("decerr_passthru", 32'(last_resp), 32'h3);
        do_txn(1'b1, 5'h04, 32'h1234_5678, 4'hF, 1'b0);
        chk("after_err_resp", 32'(last_resp), 32'h0);
        do_txn(1'b0, 5'h04, 32'h0, 4'h0, 1'b0);
        chk("after_err_readback", last_rdata, 32'h1234_5678);

        // response back-pressure with the next command already waiting
        rsp_ready = 1'b0;
        send_cmd(1'b0, 5'h08, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        cmd_write = 1'b1; cmd_addr = 5'h10; cmd_wdata = 32'hCAFE_0010; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("stall_rsp_arrived", 32'(rsp_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            chk("stall_cmd_ready_low", 32'(cmd_ready), 32'h0);
            chk("stall_rsp_valid_high", 32'(rsp_valid), 32'h1);
            #1;
        end
        rsp_ready = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin @(posedge clk); acc = cmd_valid && cmd_ready; n++; #1; end
        cmd_valid = 1'b0;
        chk("stall_accept_seen", 32'(acc), 32'h1);
        chk("stall_read_data", last_rdata, 32'h0000_00C3);
        chk("accept_after_rsp_hs", 32'(cmd_cyc - rsp_hs_cyc), 32'd1);
        wait_rsp(1'b0);
        chk("stall_second_write", 32'({last_write, last_resp}), 32'({1'b1, 2'b00}));

        // reset while ARVALID is held
        set_delays(0, 0, 0, 6, 0);
        send_cmd(1'b0, 5'h08, 32'h0, 4'h0);
        chk("pre_rst_arvalid", 32'(arvalid), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_ar_valids", 32'({arvalid, rready, rsp_valid}), 32'h0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        set_delays(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        do_txn(1'b0, 5'h08, 32'h0, 4'h0, 1'b0);
        chk("post_rst_read", last_rdata, 32'h0000_00C3);
        chk("post_rst_one_ar", 32'(ar_hs_n), 32'd1);

        for (int i = 0; i < 150; i++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            do_txn(wr, 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
            if (!wr) chk("rand_one_ar", 32'(ar_hs_n), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master (initiator) that drives the register ports of i2c_master_axil / i2c_slave_axil (M0/M1 in i2c_top_system).
- Accepts one register command (read or write) on a valid/ready command port, runs the AXI-Lite transaction, and returns data and response on a valid/ready response port.
- Used by bring-up sequencers and as the bus driver in system-level benches, replacing hand-written AXI tasks.

Parameters:
- ADDR_WIDTH, 5, AXI address width (5 for M0, 4 for M1).
- DATA_WIDTH, 32, AXI data width; STRB width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP captured from the slave
- rsp_write  out  1  echo of cmd_write
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master-side directions and widths

Behaviour:
- Reset values (applied asynchronously on rst): all *VALID, BREADY, RREADY and rsp_valid are 0; cmd_ready is 0 while rst is high; rsp_rdata, rsp_resp and rsp_write are 0; state is IDLE.
- All outputs are registered or decoded from state only. No output depends combinationally on any input.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On a cmd handshake, latch addr, wdata, wstrb and write.
  - For a write: go to WR_REQ; AWVALID and WVALID both rise the next cycle.
  - For a read: go to RD_REQ; ARVALID rises the next cycle.
- WR_REQ: AW and W are tracked independently with aw_done and w_done flags.
  - Each VALID is held, with stable payload, until its own handshake, then drops the following cycle.
  - The two handshakes may occur in the same cycle or in either order.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP.
  - A BVALID arriving before both AW and W complete is ignored, because BREADY is low.
- RD_REQ: hold ARVALID until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RSP.
- RSP:
  - rsp_valid = 1, held with stable payload until rsp_ready, then go to IDLE.
  - cmd_ready stays 0 in every state except IDLE, so there is exactly one transaction outstanding.
- Latency, with a zero-wait slave and rsp_ready held high:
  - Command accepted in cycle N.
  - AW/W (or AR) handshake in N+1.
  - B/R handshake in N+2.
  - rsp_valid in N+3.
  - Next cmd_ready in N+4.
- rsp_resp passes SLVERR (2'b10) and DECERR (2'b11) through unchanged; the FSM does no error recovery.
- Reset mid-operation:
  - Every VALID and READY drops immediately and the latched command is discarded.
  - A slave left mid-handshake is also reset in system use, because both share the same reset source.
- There is no timeout. A hung slave stalls the block indefinitely; this is intentional.

Decomposition:
- Shared package i2c_axil_pkg holds:
  - AXI response constants: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - The FSM state encoding.
  - Default ADDR_WIDTH values for M0 (5) and M1 (4).
- No sub-module is needed. The FSM and capture registers form one module.

Test Plan:
- Write, zero-wait slave: addr 5'h04, data 32'hA5A5_0001, strb 4'hF -> AW/W handshake at N+1, rsp_valid at N+3, rsp_resp = 2'b00, rsp_rdata = 0, slave register reads back 32'hA5A5_0001.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles with stable AWADDR, and BREADY rises only after the AW handshake. Repeat with W delayed instead of AW.
- Read of 5'h08 returning 32'h0000_00C3 with RVALID delayed 2 cycles -> rsp_rdata = 32'h0000_00C3, rsp_write = 0, exactly one AR handshake.
- Slave returns BRESP = 2'b10 on a write and RRESP = 2'b11 on a read -> rsp_resp = 2'b10 and 2'b11 respectively, and the next command proceeds normally.
- rsp_ready held low for 5 cycles with cmd_valid high -> rsp payload stable and cmd_ready = 0 throughout; the second command is accepted only in the cycle after the rsp handshake.
- rst pulsed while ARVALID is high -> ARVALID, RREADY and rsp_valid are 0 in the same cycle; after release, cmd_ready = 1 and a fresh read completes correctly.
